// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmitter (and the future receiver):
//   parity_mode encodings, transmitter FSM state encodings, and a helper that
//   decides whether a parity bit is part of the frame.
// -----------------------------------------------------------------------------
package uart_pkg;

  // parity_mode encodings. 2'b11 is a second spelling of "no parity".
  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_e;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // A parity bit is sent only for the even and odd encodings.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous single-clock FIFO holding words waiting for transmission.
//   The head word is visible combinationally on dout so the transmitter can
//   load it into its shift register in the same cycle it pops.
// Ports
//   clk      in   clock, rising edge
//   srst     in   synchronous active-high reset (pointers, count, overflow)
//   push     in   write din this cycle (ignored when full)
//   pop      in   drop the head word this cycle (ignored when empty)
//   din      in   WORD_SIZE  word to store
//   dout     out  WORD_SIZE  head word (valid when !empty)
//   full     out  FIFO holds FIFO_DEPTH words
//   empty    out  FIFO holds 0 words
//   count    out  clog2(FIFO_DEPTH)+1  current occupancy
//   overflow out  sticky: a push was attempted while full
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WORD_SIZE-1:0]          din,
  output logic [WORD_SIZE-1:0]          dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;

  logic push_ok;
  logic pop_ok;

  // Full/empty come from the pre-edge count, so a pop in the same cycle
  // never makes room for a write to a full FIFO.
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push && full);

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset: resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout     = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_xmtr_fifo.sv
// -----------------------------------------------------------------------------
// uart_xmtr_fifo
//   Buffered UART transmitter. Words written with wr_en are queued in a FIFO
//   and sent LSB-first as start / WORD_SIZE data / optional parity / 1-2 stop
//   bits, each bit lasting max(baud_div,1) clocks. Frames follow each other
//   with no idle gap while the FIFO has data.
// Ports
//   Clock       in   clock, rising edge
//   rst         in   synchronous active-high reset
//   Data_Bus    in   WORD_SIZE  word to queue
//   wr_en       in   push Data_Bus this cycle
//   baud_div    in   DIV_W      clocks per bit (0 behaves as 1)
//   parity_mode in   2          00 none, 01 even, 10 odd, 11 none
//   two_stop    in   1: two stop bits, 0: one
//   Serial_out  out  registered TX line, idle high
//   fifo_full   out  FIFO full
//   fifo_empty  out  FIFO empty
//   fifo_count  out  FIFO occupancy
//   busy        out  frame in progress
//   overflow    out  sticky write-while-full flag
// -----------------------------------------------------------------------------
module uart_xmtr_fifo
  import uart_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          Clock,
  input  logic                          rst,
  input  logic [WORD_SIZE-1:0]          Data_Bus,
  input  logic                          wr_en,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          Serial_out,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow
);

  localparam int BW = $clog2(WORD_SIZE);

  tx_state_e            state_q,    state_d;
  logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0]     bit_max_q,  bit_max_d;   // latched max(baud_div,1)-1
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 two_stop_q, two_stop_d;
  logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;   // data bit index / stop bit index
  logic [WORD_SIZE-1:0] shreg_q,    shreg_d;
  logic                 par_acc_q,  par_acc_d;   // XOR of data bits sent so far
  logic                 serial_q,   serial_d;
  logic                 busy_q,     busy_d;

  logic                 bit_end;
  logic                 start_frame;
  logic [WORD_SIZE-1:0] fifo_dout;

  uart_tx_fifo #(
    .WORD_SIZE  (WORD_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (Clock),
    .srst     (rst),
    .push     (wr_en),
    .pop      (start_frame),
    .din      (Data_Bus),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (overflow)
  );

  // Last clock of the current bit period.
  assign bit_end = (baud_cnt_q == bit_max_q);

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_max_d   = bit_max_q;
    par_mode_d  = par_mode_q;
    two_stop_d  = two_stop_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_acc_d   = par_acc_q;
    serial_d    = serial_q;
    start_frame = 1'b0;

    // Baud counter runs while a frame is active and restarts on every bit.
    if (state_q != ST_IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIV_W'(1);
    end

    // serial_d is always the line value for the state being entered, so the
    // registered output changes on the same edge as the state.
    case (state_q)
      ST_IDLE: begin
        serial_d   = 1'b1;
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          start_frame = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          serial_d  = shreg_q[0];
          par_acc_d = shreg_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BW'(WORD_SIZE - 1)) begin
            bit_cnt_d = '0;
            if (parity_enabled(par_mode_q)) begin
              state_d  = ST_PARITY;
              // Even: bit equals XOR of the data; odd: its complement.
              serial_d = par_acc_q ^ (par_mode_q == PAR_ODD);
            end else begin
              state_d  = ST_STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shreg_d   = shreg_q >> 1;
            serial_d  = shreg_q[1];
            par_acc_d = par_acc_q ^ shreg_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
          serial_d  = 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (two_stop_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = BW'(1);
            serial_d  = 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next frame without an idle bit.
            start_frame = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            serial_d = 1'b1;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Frame start: pop the head word, capture the line configuration for the
    // whole frame, and drive the start bit from the next edge.
    if (start_frame) begin
      state_d    = ST_START;
      shreg_d    = fifo_dout;
      bit_max_d  = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
      par_mode_d = parity_mode;
      two_stop_d = two_stop;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      par_acc_d  = 1'b0;
      serial_d   = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_max_q  <= '0;
      par_mode_q <= PAR_NONE;
      two_stop_q <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_acc_q  <= 1'b0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_max_q  <= bit_max_d;
      par_mode_q <= par_mode_d;
      two_stop_q <= two_stop_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_acc_q  <= par_acc_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
    end
  end

  assign Serial_out = serial_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_xmtr_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_xmtr_fifo
//   Directed bench for uart_xmtr_fifo (WORD_SIZE=8, FIFO_DEPTH=4, DIV_W=16).
//   A negedge recorder keeps a history of Serial_out and busy; each step
//   compares a slice of that history against hand-derived frame waveforms.
// -----------------------------------------------------------------------------
module tb_uart_xmtr_fifo;

  logic        Clock;
  logic        rst;
  logic [7:0]  Data_Bus;
  logic        wr_en;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        Serial_out;
  logic        fifo_full;
  logic        fifo_empty;
  logic [2:0]  fifo_count;
  logic        busy;
  logic        overflow;

  uart_xmtr_fifo #(
    .WORD_SIZE  (8),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .Clock       (Clock),
    .rst         (rst),
    .Data_Bus    (Data_Bus),
    .wr_en       (wr_en),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .Serial_out  (Serial_out),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // History recorder: one sample per clock, taken on the falling edge.
  localparam int HIST = 8192;
  logic line_hist [HIST];
  logic busy_hist [HIST];
  int   cyc = 0;

  always @(negedge Clock) begin
    line_hist[cyc % HIST] <= Serial_out;
    busy_hist[cyc % HIST] <= busy;
    cyc <= cyc + 1;
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Line waveform and busy-cycle count for n samples starting at history index s.
  task automatic get_wave(input int s, input int n, output logic [511:0] w, output int b);
    w = '0;
    b = 0;
    for (int k = 0; k < n; k++) begin
      w[k] = line_hist[(s + k) % HIST];
      if (busy_hist[(s + k) % HIST] === 1'b1) b++;
    end
  endtask

  // Stretch a per-bit sequence (index 0 first on the line) to div clocks per bit.
  function automatic logic [511:0] expand(input logic [63:0] bits, input int nbits, input int div);
    logic [511:0] w;
    w = '0;
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < div; c++)
        w[b*div + c] = bits[b];
    return w;
  endfunction

  // No-parity, one-stop frame: start 0, data LSB-first, stop 1.
  function automatic logic [63:0] frame_np(input logic [7:0] d);
    return {54'b0, 1'b1, d, 1'b0};
  endfunction

  // Send one word from idle with an empty FIFO and check the whole frame.
  task automatic run_frame(input string tag, input logic [7:0] d, input int nbits,
                           input int div, input logic [63:0] exp_bits);
    int           lat;
    int           s;
    int           b;
    logic [511:0] w;
    Data_Bus = d;
    wr_en    = 1'b1;
    tick();
    wr_en = 1'b0;
    check({tag, "_empty_after_write"}, fifo_empty, 1'b0);
    check({tag, "_idle_after_write"}, {busy, Serial_out}, 2'b01);
    lat = 0;
    while (Serial_out !== 1'b0 && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "_start_latency"}, lat, 1);
    s = cyc;
    repeat (nbits*div + 2) tick();
    get_wave(s, nbits*div, w, b);
    check({tag, "_wave"}, w, expand(exp_bits, nbits, div));
    get_wave(s, nbits*div + 2, w, b);
    check({tag, "_busy_cycles"}, b, nbits*div);
    $display("txn %s data=%02h bits=%0d div=%0d", tag, d, nbits, div);
  endtask

  // nw writes on consecutive cycles from idle at 1 clock per bit; exactly five
  // frames must come out back-to-back.
  task automatic burst(input string tag, input int nw, input logic exp_ovf);
    int           s;
    int           b;
    logic [511:0] w;
    logic [63:0]  exp_bits;
    exp_bits = '0;
    for (int i = 0; i < nw; i++) begin
      Data_Bus = 8'h30 + 8'(i * 17);
      wr_en    = 1'b1;
      tick();
      if (i == 0) s = cyc + 1;
      if (i < 5) exp_bits = exp_bits | (frame_np(Data_Bus) << (10 * i));
    end
    wr_en = 1'b0;
    check({tag, "_overflow"}, overflow, exp_ovf);
    check({tag, "_count_full"}, {fifo_count, fifo_full}, {3'd4, 1'b1});
    repeat (72) tick();
    get_wave(s, 50, w, b);
    check({tag, "_wave"}, w, expand(exp_bits, 50, 1));
    get_wave(s, 70, w, b);
    check({tag, "_busy_cycles"}, b, 50);
    check({tag, "_idle_after"}, {busy, Serial_out, fifo_empty}, 3'b011);
    $display("txn %s writes=%0d overflow=%0b", tag, nw, overflow);
  endtask

  initial begin
    int           s;
    int           b;
    logic [511:0] w;
    logic [511:0] e;

    rst         = 1'b1;
    wr_en       = 1'b0;
    Data_Bus    = 8'h00;
    baud_div    = 16'd4;
    parity_mode = 2'b01;
    two_stop    = 1'b0;
    tick();
    tick();
    check("rst_serial",   Serial_out, 1'b1);
    check("rst_busy",     busy,       1'b0);
    check("rst_empty",    fifo_empty, 1'b1);
    check("rst_full",     fifo_full,  1'b0);
    check("rst_count",    fifo_count, 3'd0);
    check("rst_overflow", overflow,   1'b0);
    rst = 1'b0;
    tick();

    // 0xA5, even parity, one stop, 4 clocks/bit: 0,1,0,1,0,0,1,0,1,0,1.
    run_frame("a5_even", 8'hA5, 11, 4, 64'b10101001010);

    // 0x07 three ways at 2 clocks/bit.
    baud_div = 16'd2;
    parity_mode = 2'b10;
    run_frame("07_odd", 8'h07, 11, 2, 64'b10000001110);
    parity_mode = 2'b01;
    run_frame("07_even", 8'h07, 11, 2, 64'b11000001110);
    parity_mode = 2'b11;
    run_frame("07_mode11", 8'h07, 10, 2, 64'b1000001110);

    // baud_div = 0 gives 1-clock bits.
    baud_div = 16'd0;
    parity_mode = 2'b00;
    run_frame("55_div0", 8'h55, 10, 1, 64'b1010101010);

    // Two stop bits: busy covers both stop periods.
    baud_div = 16'd2;
    two_stop = 1'b1;
    run_frame("ff_2stop", 8'hFF, 11, 2, 64'b11111111110);
    two_stop = 1'b0;

    // baud_div 4 -> 8 after the first frame started: frame A at 4, frame B at 8.
    baud_div = 16'd4;
    Data_Bus = 8'h0F;
    wr_en    = 1'b1;
    tick();
    Data_Bus = 8'hF0;
    tick();
    wr_en    = 1'b0;
    baud_div = 16'd8;
    s = cyc;
    repeat (124) tick();
    e = expand(64'b1000011110, 10, 4) | (expand(64'b1111100000, 10, 8) << 40);
    get_wave(s, 120, w, b);
    check("baud_change_wave", w, e);
    get_wave(s, 122, w, b);
    check("baud_change_busy", b, 120);
    $display("txn baud_change data=0f,f0 div=4,8");

    // FIFO bursts at 1 clock per bit.
    baud_div = 16'd1;
    parity_mode = 2'b00;
    burst("burst5", 5, 1'b0);
    do_reset();
    burst("burst6", 6, 1'b1);

    // Write on the exact cycle the FSM pops from a full FIFO.
    do_reset();
    Data_Bus = 8'h11;
    wr_en    = 1'b1;
    tick();
    for (int i = 1; i < 5; i++) begin
      Data_Bus = 8'h11 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("popfull_pre_count", {fifo_count, fifo_full}, {3'd4, 1'b1});
    repeat (6) tick();
    check("popfull_pre_state", {overflow, fifo_full, busy}, 3'b011);
    Data_Bus = 8'h99;
    wr_en    = 1'b1;
    tick();
    wr_en = 1'b0;
    check("popfull_overflow", overflow, 1'b1);
    check("popfull_count", {fifo_count, fifo_full}, {3'd3, 1'b0});
    s = cyc;
    repeat (47) tick();
    get_wave(s, 45, w, b);
    check("popfull_remaining_busy", b, 40);
    $display("txn popfull dropped=99 count=%0d", fifo_count);

    // Reset during DATA bit 3 of a frame with another word queued.
    do_reset();
    baud_div    = 16'd4;
    parity_mode = 2'b01;
    Data_Bus    = 8'h00;
    wr_en       = 1'b1;
    tick();
    tick();
    wr_en = 1'b0;
    repeat (17) tick();
    check("midrst_line_in_data", {busy, Serial_out}, 2'b10);
    rst = 1'b1;
    tick();
    check("midrst_line_high", Serial_out, 1'b1);
    check("midrst_state", {fifo_empty, busy, fifo_count}, {1'b1, 1'b0, 3'd0});
    rst = 1'b0;
    s = cyc;
    repeat (62) tick();
    get_wave(s, 60, w, b);
    check("midrst_no_frames_line", w, expand(64'hFFFF_FFFF_FFFF_FFFF, 60, 1));
    check("midrst_no_frames_busy", b, 0);
    $display("txn midframe_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
